// File: rtl/dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dump_pkg
// Purpose  : Shared state encoding and sizing constants for the dmem dump path
// Revision : 1.0
// ============================================================================
package dump_pkg;

  localparam int DUMP_DEPTH = 64;
  localparam int DUMP_IW    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : dump_pkg
`default_nettype wire

// File: rtl/dmem_dump_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_dump_arbiter
// Purpose  : Shares the data-memory port between the MEM stage and a scanner
//            that streams every doubleword out over valid/ready.
// Revision : 1.0
// ============================================================================
module dmem_dump_arbiter
  import dump_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = DUMP_DEPTH,
  parameter int IW    = DUMP_IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_writeData,
  input  logic          cpu_memWrite,
  input  logic          cpu_memRead,
  output logic [N-1:0]  cpu_readData,
  output logic          cpu_stall,
  output logic [N-1:0]  mem_addr,
  output logic [N-1:0]  mem_writeData,
  output logic          mem_writeEnable,
  output logic          mem_readEnable,
  input  logic [N-1:0]  mem_readData,
  input  logic          dump_req,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [IW-1:0] dump_index,
  output logic [N-1:0]  dump_data,
  output logic          dump_done
);

  state_t        r_state;
  state_t        w_state_next;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_next;
  logic          r_req_q;
  logic          w_start;
  logic          w_accept;
  logic          w_last;
  logic [N-1:0]  w_scan_addr;

  // A held request produces only one start because r_req_q tracks the level.
  assign w_start     = dump_req && !r_req_q;
  assign w_accept    = (r_state == SCAN) && dump_ready;
  assign w_last      = (r_idx == IW'(DEPTH - 1));
  assign w_scan_addr = {{(N-IW-3){1'b0}}, r_idx, 3'b000};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_req_q <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_req_q <= dump_req;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next = SCAN;
          w_idx_next   = '0;
        end
      end
      SCAN: begin
        // The index saturates on the last beat; DONE clears it.
        if (w_accept) begin
          if (w_last) w_state_next = DONE;
          else        w_idx_next   = r_idx + 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  always_comb begin
    mem_addr        = cpu_addr;
    mem_writeData   = cpu_writeData;
    mem_writeEnable = cpu_memWrite;
    mem_readEnable  = cpu_memRead;
    cpu_stall       = 1'b0;
    dump_valid      = 1'b0;
    dump_done       = 1'b0;
    case (r_state)
      IDLE: ;
      SCAN: begin
        mem_addr        = w_scan_addr;
        mem_writeEnable = 1'b0;
        mem_readEnable  = 1'b1;
        cpu_stall       = 1'b1;
        dump_valid      = 1'b1;
      end
      DONE: begin
        mem_addr        = w_scan_addr;
        mem_writeEnable = 1'b0;
        mem_readEnable  = 1'b0;
        cpu_stall       = 1'b1;
        dump_done       = 1'b1;
      end
      default: begin
        mem_writeEnable = 1'b0;
        mem_readEnable  = 1'b0;
      end
    endcase
  end

  assign dump_index   = r_idx;
  assign dump_data    = mem_readData;
  assign cpu_readData = mem_readData;

endmodule : dmem_dump_arbiter
`default_nettype wire

// File: tb/tb_dmem_dump_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_dump_arbiter
// Purpose  : Self-checking bench with a dmem array and a behavioural dump model
// Revision : 1.0
// ============================================================================
module tb_dmem_dump_arbiter;

  localparam int N = 64;
  localparam int D = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  cpu_addr = '0;
  logic [N-1:0]  cpu_writeData = '0;
  logic          cpu_memWrite = 1'b0;
  logic          cpu_memRead = 1'b0;
  logic [N-1:0]  cpu_readData;
  logic          cpu_stall;
  logic [N-1:0]  mem_addr;
  logic [N-1:0]  mem_writeData;
  logic          mem_writeEnable;
  logic          mem_readEnable;
  logic [N-1:0]  mem_readData;
  logic          dump_req = 1'b0;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [5:0]    dump_index;
  logic [N-1:0]  dump_data;
  logic          dump_done;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] dmem    [D];
  logic [N-1:0] ref_mem [D];

  // Reference model: scanning flag, beat number, done cycle, last request level
  bit m_active = 0;
  int m_beat   = 0;
  bit m_done   = 0;
  bit m_req_q  = 0;

  int stall_cnt = 0;
  int done_cnt  = 0;
  int bad_wr    = 0;
  logic [N-1:0] cap_data [$];
  logic [5:0]   cap_idx  [$];

  dmem_dump_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_writeData(cpu_writeData),
    .cpu_memWrite(cpu_memWrite), .cpu_memRead(cpu_memRead),
    .cpu_readData(cpu_readData), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_writeData(mem_writeData),
    .mem_writeEnable(mem_writeEnable), .mem_readEnable(mem_readEnable),
    .mem_readData(mem_readData),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  assign mem_readData = dmem[mem_addr[8:3]];
  always @(posedge clk) if (mem_writeEnable) dmem[mem_addr[8:3]] <= mem_writeData;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stall_cnt = 0;
    done_cnt  = 0;
    bad_wr    = 0;
    cap_data.delete();
    cap_idx.delete();
  endtask

  // Per-cycle compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    bit idle;
    if (!reset) begin
      chk("rst_stall", {63'b0, cpu_stall}, 64'd0);
      chk("rst_valid", {63'b0, dump_valid}, 64'd0);
      chk("rst_done",  {63'b0, dump_done}, 64'd0);
      m_active = 0; m_beat = 0; m_done = 0; m_req_q = 0;
    end else begin
      idle = !m_active && !m_done;
      if (cpu_stall) stall_cnt++;
      if (dump_done) done_cnt++;
      if (cpu_stall && mem_writeEnable) bad_wr++;
      if (dump_valid && dump_ready) begin
        cap_data.push_back(dump_data);
        cap_idx.push_back(dump_index);
      end
      chk("stall", {63'b0, cpu_stall}, {63'b0, !idle});
      chk("valid", {63'b0, dump_valid}, {63'b0, m_active});
      chk("done",  {63'b0, dump_done}, {63'b0, m_done});
      chk("wen",   {63'b0, mem_writeEnable}, {63'b0, idle && cpu_memWrite});
      if (idle) begin
        chk("pass_addr", mem_addr, cpu_addr);
        chk("pass_wdata", mem_writeData, cpu_writeData);
        chk("pass_ren", {63'b0, mem_readEnable}, {63'b0, cpu_memRead});
        if (cpu_memRead && !cpu_memWrite)
          chk("cpu_rdata", cpu_readData, ref_mem[cpu_addr[8:3]]);
      end
      if (m_active) begin
        chk("dump_index", {58'b0, dump_index}, 64'(m_beat));
        chk("dump_data", dump_data, ref_mem[m_beat]);
        chk("scan_addr", mem_addr, 64'(m_beat * 8));
        chk("scan_ren", {63'b0, mem_readEnable}, 64'd1);
      end
      // Model step for the next rising edge
      if (m_done) begin
        m_done = 0;
      end else if (m_active) begin
        if (dump_ready) begin
          if (m_beat == D - 1) begin
            m_active = 0;
            m_done   = 1;
          end else begin
            m_beat++;
          end
        end
      end else begin
        if (cpu_memWrite) ref_mem[cpu_addr[8:3]] = cpu_writeData;
        if (dump_req && !m_req_q) begin
          m_active = 1;
          m_beat   = 0;
        end
      end
      m_req_q = dump_req;
    end
  end

  task automatic check_full_dump(input string tag, input int exp_stall, input bit triple);
    chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_beats"}, 64'(cap_data.size()), 64'd64);
    chk({tag, "_bad_writes"}, 64'(bad_wr), 64'd0);
    for (int i = 0; i < cap_idx.size(); i++) begin
      chk({tag, "_beat_idx"}, {58'b0, cap_idx[i]}, 64'(i));
      if (triple) chk({tag, "_beat_data"}, cap_data[i], 64'(i * 3));
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      dmem[i]    = 64'(i * 3);
      ref_mem[i] = 64'(i * 3);
    end
    repeat (3) tick();
    chk("init_stall", {63'b0, cpu_stall}, 64'd0);
    chk("init_valid", {63'b0, dump_valid}, 64'd0);
    chk("init_done", {63'b0, dump_done}, 64'd0);
    chk("init_index", {58'b0, dump_index}, 64'd0);
    reset = 1'b1;
    tick();

    // Store then load through the pass-through path
    cpu_addr = 64'h18; cpu_writeData = 64'hDEAD_BEEF; cpu_memWrite = 1'b1;
    tick();
    cpu_memWrite = 1'b0; cpu_memRead = 1'b1;
    #1;
    chk("load_deadbeef", cpu_readData, 64'hDEAD_BEEF);
    cpu_memRead = 1'b0; cpu_writeData = 64'd9; cpu_memWrite = 1'b1;
    tick();
    cpu_memWrite = 1'b0;
    tick();

    // Full dump, ready tied high
    clear_stats();
    dump_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (80) tick();
    check_full_dump("full", 65, 1'b1);

    // Backpressure at index 10
    clear_stats();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < 40 && !(dump_valid && dump_index == 6'd10); i++) tick();
    chk("bp_reach_idx10", {58'b0, dump_index}, 64'd10);
    dump_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_hold_idx", {58'b0, dump_index}, 64'd10);
      chk("bp_hold_data", dump_data, 64'd30);
    end
    dump_ready = 1'b1;
    repeat (80) tick();
    check_full_dump("bp", 70, 1'b1);

    // Start edge coincident with a CPU write to index 0
    clear_stats();
    cpu_addr = 64'h0; cpu_writeData = 64'h55; cpu_memWrite = 1'b1; dump_req = 1'b1;
    tick();
    cpu_memWrite = 1'b0; dump_req = 1'b0;
    repeat (80) tick();
    chk("coinc_beats", 64'(cap_data.size()), 64'd64);
    if (cap_data.size() > 0) chk("coinc_first_data", cap_data[0], 64'h55);

    // Request held high starts only one dump
    clear_stats();
    dump_req = 1'b1;
    repeat (200) tick();
    dump_req = 1'b0;
    tick();
    chk("held_done_pulses", 64'(done_cnt), 64'd1);
    chk("held_stall_cycles", 64'(stall_cnt), 64'd65);

    // Asynchronous reset in the middle of a scan
    clear_stats();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < 60 && !(dump_valid && dump_index == 6'd30); i++) tick();
    chk("mid_reach_idx30", {58'b0, dump_index}, 64'd30);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_stall", {63'b0, cpu_stall}, 64'd0);
    chk("mid_rst_valid", {63'b0, dump_valid}, 64'd0);
    chk("mid_rst_index", {58'b0, dump_index}, 64'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("mid_no_done", 64'(done_cnt), 64'd0);
    clear_stats();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (80) tick();
    check_full_dump("restart", 65, 1'b0);

    // Randomized traffic, requests and backpressure
    for (int c = 0; c < 3000; c++) begin
      cpu_addr      = {55'b0, 6'($urandom_range(0, 63)), 3'b000};
      cpu_writeData = {$urandom, $urandom};
      cpu_memWrite  = ($urandom_range(0, 3) == 0);
      cpu_memRead   = ($urandom_range(0, 1) == 0);
      dump_ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) dump_req = ~dump_req;
      tick();
    end
    cpu_memWrite = 1'b0; cpu_memRead = 1'b0; dump_req = 1'b0; dump_ready = 1'b1;
    repeat (150) tick();
    chk("final_idle", {63'b0, cpu_stall}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dmem_dump_arbiter
`default_nettype wire
